// File: rtl/sram_cluster_read_encoder.sv
// ---------------------------------------------------------------------------
// sram_cluster_read_encoder
//
// Read-return path of the SRAM cluster. Each read issued to the four
// byte-wide macros carries a tag {mode, unit_2_4_dec_sel, bit_sel} down a
// pipeline matched to the macro read latency. When the tag reaches the last
// stage the macro data is valid, and the byte lanes are reassembled into a
// right-justified 32-bit fabric word. This undoes the byte-lane mapping of
// the write-side cluster decoder.
//
// Parameters:
//   READ_LATENCY      cycles from rd_req until dout_* is valid (1..4)
//
// Ports:
//   clk               cluster clock
//   rst               synchronous, active-high reset
//   rd_req            read issued to the macros this cycle
//   unit_2_4_dec_sel  macro/half select for this read
//   bit_sel           sub-byte field select for c4/c2/c1
//   c32..c1           width configuration, sampled with rd_req
//   dout_A..dout_D    macro read data
//   d_fabric_out      reassembled read word, zero-extended
//   rd_valid          one-cycle pulse marking new data on d_fabric_out
//   rd_pending        reads issued but not yet returned on rd_valid
//
// Configuration macro:
//   SRAM_CLUSTER_RD_BYPASS_EN  when defined, the output register is removed.
//                              d_fabric_out and rd_valid then come straight
//                              from the last pipeline stage, and
//                              d_fabric_out is 0 whenever rd_valid is 0.
// ---------------------------------------------------------------------------
module sram_cluster_read_encoder #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [1:0]  unit_2_4_dec_sel,
    input  logic [2:0]  bit_sel,
    input  logic        c32,
    input  logic        c16,
    input  logic        c8,
    input  logic        c4,
    input  logic        c2,
    input  logic        c1,
    input  logic [7:0]  dout_A,
    input  logic [7:0]  dout_B,
    input  logic [7:0]  dout_C,
    input  logic [7:0]  dout_D,
    output logic [31:0] d_fabric_out,
    output logic        rd_valid,
    output logic [2:0]  rd_pending
);

    typedef enum logic [2:0] {
        MODE_C32,
        MODE_C16,
        MODE_C8,
        MODE_C4,
        MODE_C2,
        MODE_C1
    } mode_t;

    typedef struct packed {
        mode_t      mode;
        logic [1:0] sel;
        logic [2:0] bit_sel;
    } tag_t;

    mode_t                   req_mode;
    tag_t                    tag_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] vld_q;
    tag_t                    last_tag;
    logic                    last_vld;
    logic [7:0]              lane_byte;
    logic [7:0]              pair_shift;
    logic [31:0]             assembled;

    // Collapse the one-hot-ish width flags into a single mode. The widest
    // flag wins. With no flag set, the read is treated as a plain byte read.
    always_comb begin
        req_mode = MODE_C8;
        if (c32)      req_mode = MODE_C32;
        else if (c16) req_mode = MODE_C16;
        else if (c8)  req_mode = MODE_C8;
        else if (c4)  req_mode = MODE_C4;
        else if (c2)  req_mode = MODE_C2;
        else if (c1)  req_mode = MODE_C1;
    end

    // Tag pipeline. One stage per cycle of macro latency. Tags are captured
    // at issue, so the mode and select inputs are free to change on the
    // following cycle. Only the valid bits need a reset. Clearing them
    // drops every read that is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_req;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
        tag_q[0] <= '{mode: req_mode, sel: unit_2_4_dec_sel, bit_sel: bit_sel};
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    assign last_tag = tag_q[READ_LATENCY-1];
    assign last_vld = vld_q[READ_LATENCY-1];

    // Reassemble the returning macro data according to the tag in the last
    // stage. The sub-byte modes first pick a byte lane in the same way as c8,
    // and then extract their field from that lane. The result lands in the
    // LSBs of the word.
    always_comb begin
        case (last_tag.sel)
            2'd0:    lane_byte = dout_A;
            2'd1:    lane_byte = dout_B;
            2'd2:    lane_byte = dout_C;
            default: lane_byte = dout_D;
        endcase
        pair_shift = lane_byte >> {last_tag.bit_sel[1:0], 1'b0};
        case (last_tag.mode)
            MODE_C32: assembled = {dout_A, dout_B, dout_C, dout_D};
            MODE_C16: assembled = last_tag.sel[0] ? {16'b0, dout_C, dout_D}
                                                  : {16'b0, dout_A, dout_B};
            MODE_C4:  assembled = {28'b0, last_tag.bit_sel[0] ? lane_byte[7:4]
                                                              : lane_byte[3:0]};
            MODE_C2:  assembled = {30'b0, pair_shift[1:0]};
            MODE_C1:  assembled = {31'b0, lane_byte[last_tag.bit_sel]};
            default:  assembled = {24'b0, lane_byte};
        endcase
    end

`ifdef SRAM_CLUSTER_RD_BYPASS_EN
    // The data-valid cycle drives the fabric directly. The output is forced
    // to zero between returns so the fabric never sees stale lanes.
    assign rd_valid     = last_vld;
    assign d_fabric_out = last_vld ? assembled : 32'b0;
`else
    // The output register adds one cycle. d_fabric_out keeps the last
    // returned word between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid     <= 1'b0;
            d_fabric_out <= 32'b0;
        end else begin
            rd_valid <= last_vld;
            if (last_vld) begin
                d_fabric_out <= assembled;
            end
        end
    end
`endif

    // Outstanding-read counter. It counts up on issue and down on the
    // rd_valid pulse. When a read is issued and another returns in the same
    // cycle, the two cancel and the count does not change.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 3'd0;
        end else begin
            case ({rd_req, rd_valid})
                2'b10:   rd_pending <= rd_pending + 3'd1;
                2'b01:   rd_pending <= rd_pending - 3'd1;
                default: rd_pending <= rd_pending;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_cluster_read_encoder.sv
// ---------------------------------------------------------------------------
// tb_sram_cluster_read_encoder
//
// Directed bench for the read-return encoder in its default build
// (registered output). Two instances share the stimulus: dut1 with
// READ_LATENCY=1 and dut3 with READ_LATENCY=3.
// ---------------------------------------------------------------------------
module tb_sram_cluster_read_encoder;

    logic        clk;
    logic        rst;
    logic        rd_req;
    logic [1:0]  unit_2_4_dec_sel;
    logic [2:0]  bit_sel;
    logic        c32, c16, c8, c4, c2, c1;
    logic [7:0]  dout_A, dout_B, dout_C, dout_D;

    logic [31:0] d_out1, d_out3;
    logic        valid1, valid3;
    logic [2:0]  pend1, pend3;

    int tests_run = 0;
    int tests_failed = 0;

    sram_cluster_read_encoder #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .rd_req(rd_req),
        .unit_2_4_dec_sel(unit_2_4_dec_sel), .bit_sel(bit_sel),
        .c32(c32), .c16(c16), .c8(c8), .c4(c4), .c2(c2), .c1(c1),
        .dout_A(dout_A), .dout_B(dout_B), .dout_C(dout_C), .dout_D(dout_D),
        .d_fabric_out(d_out1), .rd_valid(valid1), .rd_pending(pend1)
    );

    sram_cluster_read_encoder #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .rd_req(rd_req),
        .unit_2_4_dec_sel(unit_2_4_dec_sel), .bit_sel(bit_sel),
        .c32(c32), .c16(c16), .c8(c8), .c4(c4), .c2(c2), .c1(c1),
        .dout_A(dout_A), .dout_B(dout_B), .dout_C(dout_C), .dout_D(dout_D),
        .d_fabric_out(d_out3), .rd_valid(valid3), .rd_pending(pend3)
    );

    // Free-running cluster clock with a 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle. Inputs are driven and outputs sampled 1 unit after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Comparison point: the observed value must match the expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Set up the read-issue inputs: width flags {c32,c16,c8,c4,c2,c1},
    // selects and rd_req.
    task automatic applyStimulus(input logic req, input logic [5:0] flags,
                                 input logic [1:0] sel, input logic [2:0] bsel);
        rd_req           = req;
        {c32, c16, c8, c4, c2, c1} = flags;
        unit_2_4_dec_sel = sel;
        bit_sel          = bsel;
    endtask

    task automatic setDout(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        dout_A = a; dout_B = b; dout_C = c; dout_D = d;
    endtask

    // A single read on the latency-1 instance. Data is presented one cycle
    // after issue. The word is expected one cycle after that. The inputs are
    // scrambled after issue to show that the tag was captured.
    task automatic singleRead(input string tag, input logic [5:0] flags,
                              input logic [1:0] sel, input logic [2:0] bsel,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input logic [31:0] expected);
        applyStimulus(1'b1, flags, sel, bsel);
        setDout(8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        applyStimulus(1'b0, 6'b100000, ~sel, ~bsel);
        setDout(a, b, c, d);
        tick();
        setDout(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        checkOutput({tag, "_valid"}, {31'b0, valid1}, 32'd1);
        checkOutput({tag, "_data"}, d_out1, expected);
        tick();
        checkOutput({tag, "_valid_drop"}, {31'b0, valid1}, 32'd0);
        checkOutput({tag, "_hold"}, d_out1, expected);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 6'b100000, 2'd0, 3'd0);
        setDout(8'hAA, 8'hBB, 8'hCC, 8'hDD);

        // Reset is held for three cycles with rd_req high. Nothing may leak
        // out of either instance.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_valid1", {31'b0, valid1}, 32'd0);
            checkOutput("rst_pend1", {29'b0, pend1}, 32'd0);
            checkOutput("rst_data1", d_out1, 32'd0);
            checkOutput("rst_valid3", {31'b0, valid3}, 32'd0);
            checkOutput("rst_pend3", {29'b0, pend3}, 32'd0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 6'b000000, 2'd0, 3'd0);
        tick();
        checkOutput("post_rst_valid1", {31'b0, valid1}, 32'd0);
        checkOutput("post_rst_pend1", {29'b0, pend1}, 32'd0);

        // c32 read with the pending count traced cycle by cycle.
        applyStimulus(1'b1, 6'b100000, 2'd0, 3'd0);
        tick();
        applyStimulus(1'b0, 6'b000000, 2'd3, 3'd0);
        setDout(8'h11, 8'h22, 8'h33, 8'h44);
        checkOutput("c32_pend_n1", {29'b0, pend1}, 32'd1);
        checkOutput("c32_valid_n1", {31'b0, valid1}, 32'd0);
        tick();
        setDout(8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("c32_valid", {31'b0, valid1}, 32'd1);
        checkOutput("c32_data", d_out1, 32'h11223344);
        checkOutput("c32_pend_n2", {29'b0, pend1}, 32'd1);
        tick();
        checkOutput("c32_valid_drop", {31'b0, valid1}, 32'd0);
        checkOutput("c32_hold", d_out1, 32'h11223344);
        checkOutput("c32_pend_n3", {29'b0, pend1}, 32'd0);

        // Halfword, byte, nibble, pair, bit and priority cases.
        singleRead("c16_sel1", 6'b010000, 2'b01, 3'd0, 8'h12, 8'h34, 8'hAB, 8'hCD, 32'h0000ABCD);
        singleRead("c16_sel0", 6'b010000, 2'b00, 3'd0, 8'h12, 8'h34, 8'hAB, 8'hCD, 32'h00001234);
        singleRead("c4_hi", 6'b000100, 2'd1, 3'd1, 8'h00, 8'hE7, 8'h00, 8'h00, 32'h0000000E);
        singleRead("c4_lo", 6'b000100, 2'd1, 3'd0, 8'h00, 8'hE7, 8'h00, 8'h00, 32'h00000007);
        singleRead("c2_k2", 6'b000010, 2'd1, 3'd2, 8'h00, 8'hE7, 8'h00, 8'h00, 32'h00000002);
        singleRead("c1_b4", 6'b000001, 2'd2, 3'd4, 8'h00, 8'h00, 8'hEF, 8'h00, 32'h00000000);
        singleRead("noflag_c8", 6'b000000, 2'd2, 3'd0, 8'h00, 8'h00, 8'h9C, 8'h00, 32'h0000009C);
        singleRead("prio_c16", 6'b011111, 2'd0, 3'd0, 8'h5E, 8'h6F, 8'h00, 8'h00, 32'h00005E6F);

        // Back-to-back: c8 sel=3, then c1 sel=0 bit 7. The mode inputs
        // change after each issue.
        applyStimulus(1'b1, 6'b001000, 2'd3, 3'd0);
        tick();
        applyStimulus(1'b1, 6'b000001, 2'd0, 3'd7);
        setDout(8'h00, 8'h00, 8'h00, 8'h5A);
        tick();
        applyStimulus(1'b0, 6'b100000, 2'd2, 3'd0);
        setDout(8'h80, 8'h00, 8'h00, 8'h00);
        checkOutput("b2b_first_valid", {31'b0, valid1}, 32'd1);
        checkOutput("b2b_first_data", d_out1, 32'h0000005A);
        checkOutput("b2b_pend_peak", {29'b0, pend1}, 32'd2);
        tick();
        setDout(8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("b2b_second_valid", {31'b0, valid1}, 32'd1);
        checkOutput("b2b_second_data", d_out1, 32'h00000001);
        checkOutput("b2b_pend_mid", {29'b0, pend1}, 32'd1);
        tick();
        checkOutput("b2b_valid_drop", {31'b0, valid1}, 32'd0);
        checkOutput("b2b_pend_end", {29'b0, pend1}, 32'd0);

        // Latency-3 instance: a single c32 read. Data is valid exactly three
        // cycles after issue and appears on the fabric one cycle later.
        rst = 1'b1;
        applyStimulus(1'b0, 6'b000000, 2'd0, 3'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 6'b100000, 2'd0, 3'd0);
        tick();
        applyStimulus(1'b0, 6'b000000, 2'd0, 3'd0);
        setDout(8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        setDout(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        checkOutput("l3_valid_early", {31'b0, valid3}, 32'd0);
        tick();
        setDout(8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("l3_valid", {31'b0, valid3}, 32'd1);
        checkOutput("l3_data", d_out3, 32'hDEADBEEF);
        tick();
        checkOutput("l3_valid_drop", {31'b0, valid3}, 32'd0);
        checkOutput("l3_pend_end", {29'b0, pend3}, 32'd0);

        // Latency-3 instance: two reads, then reset while both are in
        // flight. Neither read may ever return.
        applyStimulus(1'b1, 6'b100000, 2'd0, 3'd0);
        tick();
        applyStimulus(1'b1, 6'b001000, 2'd1, 3'd0);
        tick();
        applyStimulus(1'b0, 6'b000000, 2'd0, 3'd0);
        checkOutput("l3_rst_pend_before", {29'b0, pend3}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("l3_rst_pend_after", {29'b0, pend3}, 32'd0);
        checkOutput("l3_rst_data_after", d_out3, 32'd0);
        setDout(8'h11, 8'h22, 8'h33, 8'h44);
        for (int i = 0; i < 6; i++) begin
            checkOutput("l3_rst_no_valid", {31'b0, valid3}, 32'd0);
            checkOutput("l3_rst_pend_idle", {29'b0, pend3}, 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog: the bench must never hang.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
